// File: rtl/orion_pkg.sv
// Shared constants, FSM state encoding and LFSR step function for the digit
// sequence store and its consumers.
package orion_pkg;

  localparam int                 DIGIT_W   = 4;
  localparam int                 ADDR_W    = 5;
  localparam int                 SEQ_LEN   = 2 ** ADDR_W;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(9);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(SEQ_LEN - 1);
  localparam logic [15:0]        LFSR_SEED = 16'hACE1;
  localparam logic [15:0]        LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Galois form: shift right, fold the taps in when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  function automatic logic [DIGIT_W-1:0] digit_of(input logic [15:0] v);
    return v[DIGIT_W-1:0];
  endfunction

endpackage

// File: rtl/orion_lfsr16.sv
// Free-running 16-bit Galois LFSR; advances every cycle out of reset.
// A zero seed would lock the register, so it is replaced by 1.
module orion_lfsr16
  import orion_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb lfsr_d = lfsr_step(lfsr_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/digit_sequence_store.sv
// Fills SEQ_LEN random digits (0..MAX_DIGIT) on go_gen and holds them for
// playback through a registered, 1-cycle-latency read port.
module digit_sequence_store
  import orion_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go_gen,
  output logic               fin_gen,
  output logic               seq_valid,
  output logic               busy,
  input  logic [ADDR_W-1:0]  seq_addr,
  output logic [DIGIT_W-1:0] ram_output
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic               fin_q, fin_d;
  logic [15:0]        lfsr;
  logic [DIGIT_W-1:0] cand;
  logic               accept;
  logic               wr_en;
  logic [DIGIT_W-1:0] mem [SEQ_LEN];
  logic [DIGIT_W-1:0] rd_q;

  orion_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  // Out-of-range nibbles are skipped rather than folded, keeping digits unbiased.
  assign cand   = digit_of(lfsr);
  assign accept = (cand <= MAX_DIGIT);
  assign wr_en  = rst && (state_q == FILL) && accept;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    fin_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_gen) begin
          state_d  = FILL;
          wr_ptr_d = '0;
        end
      end
      FILL: begin
        if (accept) begin
          if (wr_ptr_q == LAST_ADDR) begin
            state_d = DONE;
            fin_d   = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (go_gen) begin
          state_d  = FILL;
          wr_ptr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      fin_q    <= fin_d;
    end
  end

  // Contents survive reset; consumers gate on seq_valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= cand;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem[seq_addr];
    end
  end

  assign ram_output = rd_q;
  assign fin_gen    = fin_q;
  assign seq_valid  = (state_q == DONE);
  assign busy       = (state_q == FILL);

endmodule
